// File: rtl/minmax_window_ctrl_pkg.sv
// Shared types and default widths for the windowed min/max controller.
package minmax_window_ctrl_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int CNT_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FIRST = 2'd1,
      ST_ACCUM = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

endpackage

// File: rtl/minmax_window_ctrl_if.sv
// Sample-in / result-out handshake bundle between source, controller and consumer.
interface minmax_window_ctrl_if
   import minmax_window_ctrl_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
);
   logic             start;
   logic [CNT_W-1:0] win_len;
   logic             signed_mode;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] min_out;
   logic [WIDTH-1:0] max_out;
   logic             busy;
   logic             err;

   modport master (
      output start, win_len, signed_mode, in_valid, in_data, out_ready,
      input  in_ready, out_valid, min_out, max_out, busy, err
   );

   modport slave (
      input  start, win_len, signed_mode, in_valid, in_data, out_ready,
      output in_ready, out_valid, min_out, max_out, busy, err
   );
endinterface

// File: rtl/minmax_window_ctrl_update.sv
// Combinational min/max update of one sample against the running extremes.
module minmax_update
   import minmax_window_ctrl_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] i_sample,
   input  logic [WIDTH-1:0] i_cur_min,
   input  logic [WIDTH-1:0] i_cur_max,
   input  logic             i_signed,
   output logic [WIDTH-1:0] o_nxt_min,
   output logic [WIDTH-1:0] o_nxt_max
);
   logic w_lt_min;
   logic w_gt_max;

   // strict compares so equal samples leave the extremes untouched
   always_comb begin
      if (i_signed) begin
         w_lt_min = $signed(i_sample) < $signed(i_cur_min);
         w_gt_max = $signed(i_sample) > $signed(i_cur_max);
      end else begin
         w_lt_min = i_sample < i_cur_min;
         w_gt_max = i_sample > i_cur_max;
      end
   end

   assign o_nxt_min = w_lt_min ? i_sample : i_cur_min;
   assign o_nxt_max = w_gt_max ? i_sample : i_cur_max;
endmodule

// File: rtl/minmax_window_ctrl.sv
// Windowed min/max controller: accepts win_len samples, then holds the result
// until the consumer takes it.
//
//   state    | meaning
//   ST_IDLE  | waiting for start, last result still visible
//   ST_FIRST | waiting for first sample, which seeds min and max
//   ST_ACCUM | folding further samples into min/max
//   ST_HOLD  | result valid, waiting for out_ready
module minmax_window_ctrl
   import minmax_window_ctrl_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   minmax_window_ctrl_if.slave  bus
);
   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_len;
   logic [CNT_W-1:0] r_cnt;
   logic             r_signed;
   logic [WIDTH-1:0] r_min;
   logic [WIDTH-1:0] r_max;
   logic             r_err;

   logic             w_in_ready;
   logic             w_out_valid;
   logic             w_busy;
   logic             w_accept;
   logic             w_start_ok;
   logic             w_start_bad;
   logic [CNT_W-1:0] w_cnt_inc;
   logic [WIDTH-1:0] w_nxt_min;
   logic [WIDTH-1:0] w_nxt_max;

   assign w_accept    = bus.in_valid & w_in_ready;
   assign w_start_ok  = (r_state == ST_IDLE) & bus.start & (bus.win_len != '0);
   assign w_start_bad = (r_state == ST_IDLE) & bus.start & (bus.win_len == '0);
   assign w_cnt_inc   = r_cnt + CNT_W'(1);

   minmax_update #(.WIDTH(WIDTH)) u_update (
      .i_sample  (bus.in_data),
      .i_cur_min (r_min),
      .i_cur_max (r_max),
      .i_signed  (r_signed),
      .o_nxt_min (w_nxt_min),
      .o_nxt_max (w_nxt_max)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      w_busy      = 1'b1;
      case (r_state)
         ST_IDLE: begin
            w_busy = 1'b0;
            if (w_start_ok) w_state_nxt = ST_FIRST;
         end
         ST_FIRST: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) begin
               w_state_nxt = (r_len == CNT_W'(1)) ? ST_HOLD : ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            w_in_ready = 1'b1;
            if (bus.in_valid && (w_cnt_inc == r_len)) w_state_nxt = ST_HOLD;
         end
         ST_HOLD: begin
            w_out_valid = 1'b1;
            if (bus.out_ready) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_len    <= '0;
         r_cnt    <= '0;
         r_signed <= 1'b0;
         r_min    <= '0;
         r_max    <= '0;
         r_err    <= 1'b0;
      end else begin
         r_err <= w_start_bad;
         if (w_start_ok) begin
            r_len    <= bus.win_len;
            r_signed <= bus.signed_mode;
         end
         if (w_accept) begin
            if (r_state == ST_FIRST) begin
               r_min <= bus.in_data;
               r_max <= bus.in_data;
               r_cnt <= CNT_W'(1);
            end else begin
               r_min <= w_nxt_min;
               r_max <= w_nxt_max;
               r_cnt <= w_cnt_inc;
            end
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.busy      = w_busy;
   assign bus.err       = r_err;
   assign bus.min_out   = r_min;
   assign bus.max_out   = r_max;
endmodule

// File: tb/tb_minmax_window_ctrl.sv
// Self-checking bench for minmax_window_ctrl: table of windows plus hand-written corner sequences.
module tb_minmax_window_ctrl;
   import minmax_window_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errs = 0;

   always #5 clk = ~clk;

   minmax_window_ctrl_if #(.WIDTH(32), .CNT_W(8)) bus ();

   minmax_window_ctrl #(.WIDTH(32), .CNT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      bit               sgn;
      logic [7:0]       len;
      logic [3:0][31:0] s;
      int               gap;
      logic [31:0]      emin;
      logic [31:0]      emax;
   } vec_t;

   typedef struct {
      logic [31:0] emin;
      logic [31:0] emax;
   } exp_t;

   vec_t vecs[6];
   exp_t sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
      end
   endtask

   task automatic start_win(input bit sgn, input logic [7:0] len);
      bus.start       = 1'b1;
      bus.win_len     = len;
      bus.signed_mode = sgn;
      @(posedge clk); #1;
      bus.start = 1'b0;
      // later changes to length and mode must not affect the running window
      bus.win_len     = 8'd1;
      bus.signed_mode = ~sgn;
   endtask

   task automatic send(input logic [31:0] d, input int gap);
      bit acc;
      int t;
      repeat (gap) begin
         @(negedge clk);
         check("no_result_in_gap", {31'd0, bus.out_valid}, 32'd0);
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      acc = 1'b0;
      t = 0;
      do begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk); #1;
         t++;
      end while (!acc && t < 20);
      bus.in_valid = 1'b0;
      bus.in_data  = 32'hDEAD_BEEF;
      if (!acc) begin
         n_checks++;
         n_errs++;
         $display("FAIL accept_timeout: in_ready never high, want 1");
      end
   endtask

   // expects out_valid right after the last accept; consumes with optional start in the same cycle
   task automatic collect(input string name, input bit start_with_ready);
      exp_t e;
      @(negedge clk);
      check({name, "_out_valid"}, {31'd0, bus.out_valid}, 32'd1);
      check({name, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
      if (sb.size() == 0) begin
         n_checks++;
         n_errs++;
         $display("FAIL %s_scoreboard: queue empty, want 1 entry", name);
      end else begin
         e = sb.pop_front();
         check({name, "_min"}, bus.min_out, e.emin);
         check({name, "_max"}, bus.max_out, e.emax);
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      bus.start     = start_with_ready;
      bus.win_len   = 8'd2;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      bus.start     = 1'b0;
      @(negedge clk);
      check({name, "_out_valid_clr"}, {31'd0, bus.out_valid}, 32'd0);
      check({name, "_busy_clr"}, {31'd0, bus.busy}, 32'd0);
      check({name, "_min_retained"}, bus.min_out, e.emin);
      @(posedge clk); #1;
   endtask

   task automatic run_vec(input int i);
      start_win(vecs[i].sgn, vecs[i].len);
      @(negedge clk);
      check($sformatf("v%0d_busy", i), {31'd0, bus.busy}, 32'd1);
      check($sformatf("v%0d_in_ready", i), {31'd0, bus.in_ready}, 32'd1);
      sb.push_back('{emin: vecs[i].emin, emax: vecs[i].emax});
      @(posedge clk); #1;
      for (int k = 0; k < int'(vecs[i].len); k++) send(vecs[i].s[k], vecs[i].gap);
      collect($sformatf("v%0d", i), 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, want finish");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{sgn: 0, len: 8'd4, s: {32'd5, 32'd9, 32'd3, 32'd7}, gap: 0, emin: 32'd3, emax: 32'd9};
      vecs[1] = '{sgn: 1, len: 8'd3, s: {32'd0, 32'h8000_0000, 32'd5, 32'hFFFF_FFFE}, gap: 0,
                  emin: 32'h8000_0000, emax: 32'd5};
      vecs[2] = '{sgn: 0, len: 8'd3, s: {32'd0, 32'h8000_0000, 32'd5, 32'hFFFF_FFFE}, gap: 0,
                  emin: 32'd5, emax: 32'hFFFF_FFFE};
      vecs[3] = '{sgn: 0, len: 8'd3, s: {32'd0, 32'd10, 32'd10, 32'd10}, gap: 2, emin: 32'd10, emax: 32'd10};
      vecs[4] = '{sgn: 1, len: 8'd4, s: {32'd1, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, gap: 1,
                  emin: 32'hFFFF_FFFF, emax: 32'd1};
      vecs[5] = '{sgn: 0, len: 8'd2, s: {32'd0, 32'd0, 32'd2, 32'd1}, gap: 0, emin: 32'd1, emax: 32'd2};

      bus.start = 1'b0; bus.win_len = '0; bus.signed_mode = 1'b0;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_err", {31'd0, bus.err}, 32'd0);
      check("rst_min", bus.min_out, 32'd0);
      check("rst_max", bus.max_out, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 5; i++) run_vec(i);

      // single-sample window held for 5 cycles with stray in_valid traffic
      start_win(1'b0, 8'd1);
      sb.push_back('{emin: 32'd42, emax: 32'd42});
      send(32'd42, 0);
      bus.in_valid = 1'b1;
      bus.in_data  = 32'd1000;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("hold_out_valid", {31'd0, bus.out_valid}, 32'd1);
         check("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
         check("hold_min", bus.min_out, 32'd42);
         check("hold_max", bus.max_out, 32'd42);
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      collect("len1", 1'b0);

      // zero-length start
      bus.start = 1'b1; bus.win_len = 8'd0;
      @(negedge clk);
      check("err_before_edge", {31'd0, bus.err}, 32'd0);
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("err_pulse", {31'd0, bus.err}, 32'd1);
      check("err_busy", {31'd0, bus.busy}, 32'd0);
      @(posedge clk); #1;
      check("err_clear", {31'd0, bus.err}, 32'd0);
      check("err_still_idle", {31'd0, bus.busy}, 32'd0);

      // start during ACCUM is ignored; start during the output handshake too
      start_win(1'b0, 8'd3);
      sb.push_back('{emin: 32'd4, emax: 32'd8});
      send(32'd4, 0);
      bus.start = 1'b1; bus.win_len = 8'd1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      send(32'd8, 0);
      @(negedge clk);
      check("accum_no_early_result", {31'd0, bus.out_valid}, 32'd0);
      @(posedge clk); #1;
      send(32'd6, 0);
      collect("restart", 1'b1);
      check("restart_still_idle", {31'd0, bus.busy}, 32'd0);

      // reset mid-window
      start_win(1'b0, 8'd4);
      send(32'd77, 0);
      send(32'd88, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_busy", {31'd0, bus.busy}, 32'd0);
      check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("midrst_min", bus.min_out, 32'd0);
      check("midrst_max", bus.max_out, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_vec(5);

      check("scoreboard_drained", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end
endmodule
